// File: rtl/fp_normalize_pack.sv
// Post-add normalization and IEEE-754 single-precision packing.
// Three-stage global-stall pipeline: leading-zero count, shift/exponent adjust, pack/flag.
module fp_normalize_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_man,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_underflow,
    output logic        out_zero
);

    // Leading zeros of the 24-bit hidden+fraction field; 24 when the field is empty.
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd24;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(23 - i);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return n;
    endfunction

    logic        advance_s;
    logic        s1_valid_r, s1_sign_r, s1_carry_r, s1_zero_r;
    logic [7:0]  s1_exp_r;
    logic [24:0] s1_man_r;
    logic [4:0]  s1_lzc_r;
    logic        s2_valid_r, s2_sign_r, s2_ovf_r, s2_udf_r, s2_zero_r;
    logic [8:0]  s2_exp_r;
    logic [23:0] s2_man_r;
    logic [8:0]  s2_exp_s;
    logic [23:0] s2_man_s;
    logic        s2_ovf_s, s2_udf_s, s2_zero_s;
    logic [31:0] s3_result_s;

    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;

    // Stage 1: capture the beat with its leading-zero count, carry and zero indication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_exp_r   <= 8'd0;
            s1_man_r   <= 25'd0;
            s1_lzc_r   <= 5'd0;
            s1_carry_r <= 1'b0;
            s1_zero_r  <= 1'b0;
        end else if (advance_s) begin
            s1_valid_r <= in_valid;
            s1_sign_r  <= in_sign;
            s1_exp_r   <= in_exp;
            s1_man_r   <= in_man;
            s1_lzc_r   <= lzc24(in_man[23:0]);
            s1_carry_r <= in_man[24];
            s1_zero_r  <= (in_man == 25'd0);
        end
    end

    // Renormalize: zero wins, then carry (right by one, truncating), then left shift or flush.
    always_comb begin
        s2_man_s  = 24'd0;
        s2_exp_s  = 9'd0;
        s2_ovf_s  = 1'b0;
        s2_udf_s  = 1'b0;
        s2_zero_s = 1'b0;
        if (s1_zero_r) begin
            s2_zero_s = 1'b1;
        end else if (s1_carry_r) begin
            s2_man_s = s1_man_r[24:1];
            s2_exp_s = {1'b0, s1_exp_r} + 9'd1;
            s2_ovf_s = (s2_exp_s >= 9'd255);
        end else if (s1_exp_r > {3'd0, s1_lzc_r}) begin
            s2_man_s = s1_man_r[23:0] << s1_lzc_r;
            s2_exp_s = {1'b0, s1_exp_r} - {4'd0, s1_lzc_r};
        end else begin
            s2_udf_s = 1'b1;
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_sign_r  <= 1'b0;
            s2_exp_r   <= 9'd0;
            s2_man_r   <= 24'd0;
            s2_ovf_r   <= 1'b0;
            s2_udf_r   <= 1'b0;
            s2_zero_r  <= 1'b0;
        end else if (advance_s) begin
            s2_valid_r <= s1_valid_r;
            s2_sign_r  <= s1_sign_r;
            s2_exp_r   <= s2_exp_s;
            s2_man_r   <= s2_man_s;
            s2_ovf_r   <= s2_ovf_s;
            s2_udf_r   <= s2_udf_s;
            s2_zero_r  <= s2_zero_s;
        end
    end

    // Pack the word; special cases replace the exponent/fraction fields.
    always_comb begin
        s3_result_s = 32'd0;
        case ({s2_ovf_r, s2_udf_r, s2_zero_r})
            3'b000:  s3_result_s = {s2_sign_r, s2_exp_r[7:0], s2_man_r[22:0]};
            3'b100:  s3_result_s = {s2_sign_r, 8'hFF, 23'd0};
            3'b010:  s3_result_s = {s2_sign_r, 31'd0};
            3'b001:  s3_result_s = 32'd0;
            default: s3_result_s = 32'd0;
        endcase
    end

    // Output stage; flags and result are forced low for bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_result    <= 32'd0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_zero      <= 1'b0;
        end else if (advance_s) begin
            out_valid     <= s2_valid_r;
            out_result    <= s2_valid_r ? s3_result_s : 32'd0;
            out_overflow  <= s2_valid_r & s2_ovf_r;
            out_underflow <= s2_valid_r & s2_udf_r;
            out_zero      <= s2_valid_r & s2_zero_r;
        end
    end

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Directed self-checking bench for fp_normalize_pack: latency, packing, flags,
// backpressure ordering and asynchronous reset mid-stream.
module tb_fp_normalize_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_man;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_zero;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-computed vectors: {sign, exp, man} -> result, flags {ovf, udf, zero}.
    localparam int NV = 13;
    logic        v_sign [NV];
    logic [7:0]  v_exp  [NV];
    logic [24:0] v_man  [NV];
    logic [31:0] v_res  [NV];
    logic [2:0]  v_flg  [NV];

    // Backpressure stream: six distinct normal results.
    logic        b_sign [6];
    logic [7:0]  b_exp  [6];
    logic [24:0] b_man  [6];
    logic [31:0] b_res  [6];

    fp_normalize_pack dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_overflow(out_overflow),
        .out_underflow(out_underflow), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, req);
        end
    endtask

    // Called 1 time unit after a rising edge with an empty pipeline and out_ready high.
    task automatic send_and_check(input int k);
        in_sign  = v_sign[k];
        in_exp   = v_exp[k];
        in_man   = v_man[k];
        in_valid = 1'b1;
        check($sformatf("in_ready_%0d", k), {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check($sformatf("lat1_%0d", k), {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1 check($sformatf("lat2_%0d", k), {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1 check($sformatf("valid_%0d", k), {31'd0, out_valid}, 32'd1);
        check($sformatf("result_%0d", k), out_result, v_res[k]);
        check($sformatf("flags_%0d", k), {29'd0, out_overflow, out_underflow, out_zero},
              {29'd0, v_flg[k]});
        @(posedge clk);
        #1;
    endtask

    initial begin
        v_sign = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        v_exp  = '{8'h7F, 8'h80, 8'h90, 8'hFE, 8'hFF, 8'hFF, 8'h03, 8'h00, 8'h01, 8'h02,
                   8'hFD, 8'h00, 8'h7F};
        v_man  = '{25'h1800000, 25'h0400000, 25'h0000001, 25'h1000000, 25'h1000000,
                   25'h1000000, 25'h0000010, 25'h0000000, 25'h0400000, 25'h0400000,
                   25'h1000000, 25'h0800000, 25'h1FFFFFF};
        v_res  = '{32'h40400000, 32'h3F800000, 32'h3C800000, 32'hFF800000, 32'h7F800000,
                   32'hFF800000, 32'h80000000, 32'h00000000, 32'h80000000, 32'h00800000,
                   32'h7F000000, 32'h00000000, 32'h407FFFFF};
        v_flg  = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b010,
                   3'b000, 3'b000, 3'b010, 3'b000};
        b_sign = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        b_exp  = '{8'h7F, 8'h7F, 8'h80, 8'h90, 8'hFD, 8'h02};
        b_man  = '{25'h1800000, 25'h1800000, 25'h0400000, 25'h0000001, 25'h1000000,
                   25'h0400000};
        b_res  = '{32'h40400000, 32'hC0400000, 32'h3F800000, 32'h3C800000, 32'h7F000000,
                   32'h00800000};

        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'd0; in_man = 25'd0;
        out_ready = 1'b1;
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_flags", {29'd0, out_overflow, out_underflow, out_zero}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < NV; k++) send_and_check(k);

        // Backpressure: six beats offered back-to-back, out_ready low for five edges.
        out_ready = 1'b0;
        fork
            begin : driver
                for (int k = 0; k < 6; k++) begin
                    logic acc;
                    int   tries;
                    in_sign = b_sign[k]; in_exp = b_exp[k]; in_man = b_man[k];
                    in_valid = 1'b1;
                    tries = 0;
                    acc = 1'b0;
                    while (!acc && tries < 50) begin
                        #1 acc = in_ready;
                        @(posedge clk);
                        #1;
                        tries++;
                    end
                    if (!acc) check($sformatf("bp_accept_%0d", k), 32'd0, 32'd1);
                end
                in_valid = 1'b0;
            end
            begin : stall
                repeat (3) @(posedge clk);
                #1;
                check("bp_full_valid", {31'd0, out_valid}, 32'd1);
                check("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
                check("bp_full_result", out_result, b_res[0]);
                repeat (2) begin
                    @(posedge clk);
                    #1;
                    check("bp_stall_in_ready", {31'd0, in_ready}, 32'd0);
                    check("bp_stall_result", out_result, b_res[0]);
                end
                out_ready = 1'b1;
            end
            begin : monitor
                int idx;
                idx = 0;
                for (int c = 0; c < 200 && idx < 6; c++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        check($sformatf("bp_order_%0d", idx), out_result, b_res[idx]);
                        idx++;
                    end
                end
                check("bp_count", idx, 32'd6);
            end
        join
        @(posedge clk);
        #1 check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Reset with three beats in flight.
        for (int k = 0; k < 3; k++) begin
            in_sign = v_sign[k + 3]; in_exp = v_exp[k + 3]; in_man = v_man[k + 3];
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_result", out_result, 32'd0);
        check("mid_rst_flags", {29'd0, out_overflow, out_underflow, out_zero}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        send_and_check(0);
        send_and_check(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
